// File: rtl/axi4_wr_slave_mem_if.sv
// rtl/axi4_wr_slave_mem_if.sv - AXI4 write-path (AW/W/B) channel bundle
interface axi4_wr_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [1:0]            AWBURST;
  logic [ID_WIDTH-1:0]   AWID;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWLEN, AWBURST, AWID, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWBURST, AWID, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_wr_slave_mem.sv
// rtl/axi4_wr_slave_mem.sv - RAM-backed AXI4 write slave, one burst at a time; AXI4_WR_SLV_WLAST_CHK_EN enables WLAST checking
module axi4_wr_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  axi4_wr_slave_mem_if.slave           axi,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SHIFT      = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state, state_nxt;

  logic awready_d, wready_d, bvalid_d;
  logic aw_hs, w_hs, b_hs;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt, addr_inc, win_bytes, wrap_mask, word_full;
  logic [7:0] len, beat_cnt;
  logic [1:0] burst;
  logic [ID_WIDTH-1:0] id;
  logic err, no_write, bad_burst, in_range, last_beat, wlast_err, beat_err, wr_en;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign aw_hs = axi.AWVALID & axi.AWREADY;
  assign w_hs  = axi.WVALID & axi.WREADY;
  assign b_hs  = axi.BVALID & axi.BREADY;

  assign word_full = addr >> SHIFT;
  assign in_range  = word_full < ADDR_WIDTH'(MEM_DEPTH);
  assign last_beat = (beat_cnt == len);

`ifdef AXI4_WR_SLV_WLAST_CHK_EN
  assign wlast_err = (axi.WLAST != last_beat);
`else
  logic unused_wlast;
  assign unused_wlast = axi.WLAST;
  assign wlast_err    = 1'b0;
`endif

  assign beat_err = ~in_range | wlast_err;
  assign wr_en    = w_hs & ~no_write & in_range & ~ARESET;

  // Reserved bursts and illegal WRAP lengths consume beats but never touch memory.
  always_comb begin
    bad_burst = 1'b0;
    if (axi.AWBURST == 2'b11)
      bad_burst = 1'b1;
    else if (axi.AWBURST == 2'b10 && !(axi.AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}))
      bad_burst = 1'b1;
  end

  assign win_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << SHIFT;
  assign wrap_mask = win_bytes - ADDR_WIDTH'(1);

  always_comb begin
    addr_inc = addr + ADDR_WIDTH'(STRB_WIDTH);
    case (burst)
      2'b00:   addr_nxt = addr;
      2'b10:   addr_nxt = (addr & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_nxt = addr_inc;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      axi.AWREADY <= 1'b0;
      axi.WREADY  <= 1'b0;
      axi.BVALID  <= 1'b0;
    end else begin
      state       <= state_nxt;
      axi.AWREADY <= awready_d;
      axi.WREADY  <= wready_d;
      axi.BVALID  <= bvalid_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aw_hs) state_nxt = DATA;
      DATA:    if (w_hs && last_beat) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they land in flops.
  always_comb begin
    awready_d = (state_nxt == IDLE);
    wready_d  = (state_nxt == DATA);
    bvalid_d  = (state_nxt == RESP);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr      <= '0;
      len       <= '0;
      burst     <= '0;
      id        <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      no_write  <= 1'b0;
      axi.BID   <= '0;
      axi.BRESP <= 2'b00;
    end else if (aw_hs) begin
      addr     <= axi.AWADDR & ~ADDR_WIDTH'(STRB_WIDTH - 1);
      len      <= axi.AWLEN;
      burst    <= axi.AWBURST;
      id       <= axi.AWID;
      beat_cnt <= '0;
      err      <= bad_burst;
      no_write <= bad_burst;
    end else if (w_hs) begin
      beat_cnt <= beat_cnt + 8'd1;
      addr     <= addr_nxt;
      err      <= err | beat_err;
      if (last_beat) begin
        axi.BID   <= id;
        axi.BRESP <= (err | beat_err) ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (axi.WSTRB[i])
          mem[word_full[IDX_W-1:0]][i*8 +: 8] <= axi.WDATA[i*8 +: 8];
      end
    end
  end

  assign dbg_data = mem[dbg_addr];
endmodule
